// File: rtl/btn_rpt.sv
// Debounced, auto-repeating front end for the three active-low set keys.
// Emits one-cycle command pulses on press and, on enabled channels, while held.
module btn_rpt #(
  parameter int unsigned SAMPLE_DIV   = 500000,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10,
  parameter logic [2:0]  REPEAT_MASK  = 3'b110
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] nBIN,
  output logic [2:0] BOUT,
  output logic [2:0] LEVEL
);

  localparam int unsigned TW   = $clog2(SAMPLE_DIV);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [TW-1:0] TickLast  = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] DelayLast = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RateLast  = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {StIdle, StWait, StRpt} state_e;

  logic [2:0]    sync_q, s_q;
  logic [TW-1:0] div_q, div_d;
  logic          tick;
  logic [2:0]    prev_q, level_q, level_d;
  logic [2:0]    bout_q, bout_d;
  state_e        state_q [3];
  state_e        state_d [3];
  logic [CW-1:0] rcnt_q  [3];
  logic [CW-1:0] rcnt_d  [3];

  assign tick  = (div_q == TickLast);
  assign div_d = tick ? '0 : div_q + 1'b1;

  // A channel level only follows the sample once two consecutive ticks agree.
  always_comb begin
    level_d = level_q;
    if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (s_q[i] == prev_q[i]) level_d[i] = s_q[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync_q  <= '0;
      s_q     <= '0;
      div_q   <= '0;
      prev_q  <= '0;
      level_q <= '0;
      bout_q  <= '0;
    end else begin
      sync_q  <= ~nBIN;
      s_q     <= sync_q;
      div_q   <= div_d;
      if (tick) prev_q <= s_q;
      level_q <= level_d;
      bout_q  <= bout_d;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= StIdle;
        rcnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end

  // FSM next state; release is checked before any counting.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      if (tick) begin
        case (state_q[i])
          StIdle: begin
            if (level_d[i] && !level_q[i]) begin
              state_d[i] = StWait;
              rcnt_d[i]  = '0;
            end
          end
          StWait: begin
            if (!level_d[i]) begin
              state_d[i] = StIdle;
            end else if (REPEAT_MASK[i]) begin
              if (rcnt_q[i] == DelayLast) begin
                state_d[i] = StRpt;
                rcnt_d[i]  = '0;
              end else begin
                rcnt_d[i] = rcnt_q[i] + 1'b1;
              end
            end
          end
          StRpt: begin
            if (!level_d[i]) begin
              state_d[i] = StIdle;
            end else if (rcnt_q[i] == RateLast) begin
              rcnt_d[i] = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + 1'b1;
            end
          end
          default: state_d[i] = StIdle;
        endcase
      end
    end
  end

  // FSM outputs, registered into bout_q
  always_comb begin
    bout_d = '0;
    if (tick) begin
      for (int i = 0; i < 3; i++) begin
        case (state_q[i])
          StIdle:  bout_d[i] = level_d[i] & ~level_q[i];
          StWait:  bout_d[i] = level_d[i] & REPEAT_MASK[i] & (rcnt_q[i] == DelayLast);
          StRpt:   bout_d[i] = level_d[i] & (rcnt_q[i] == RateLast);
          default: bout_d[i] = 1'b0;
        endcase
      end
    end
  end

  assign BOUT  = bout_q;
  assign LEVEL = level_q;

endmodule

// File: tb/tb_btn_rpt.sv
// Bench for btn_rpt: tick-level reference model plus scenario-specific pulse counts
// and spacings, with randomized key patterns and resets.
module tb_btn_rpt;

  localparam int SD   = 4;
  localparam int DLY  = 3;
  localparam int RATE = 2;
  localparam logic [2:0] MASK = 3'b110;

  logic       clk;
  logic       rst;
  logic [2:0] nbin;
  logic [2:0] bout;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  btn_rpt #(
    .SAMPLE_DIV  (SD),
    .REPEAT_DELAY(DLY),
    .REPEAT_RATE (RATE),
    .REPEAT_MASK (MASK)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .nBIN (nbin),
    .BOUT (bout),
    .LEVEL(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: key history, tick index and "ticks held since press" per key.
  logic [2:0] h1, h2, m_prev, exp_bout, exp_level;
  int         m_cyc;
  int         m_k [3];

  task automatic model_edge();
    logic [2:0] s, nl, pulse;
    if (!rst) begin
      h1 = '0; h2 = '0; m_prev = '0; exp_bout = '0; exp_level = '0; m_cyc = 0;
      for (int i = 0; i < 3; i++) m_k[i] = -1;
    end else begin
      s = h2;
      h2 = h1;
      h1 = ~nbin;
      nl = exp_level;
      pulse = '0;
      if (m_cyc % SD == SD - 1) begin
        for (int i = 0; i < 3; i++) if (s[i] == m_prev[i]) nl[i] = s[i];
        m_prev = s;
        for (int i = 0; i < 3; i++) begin
          if (!nl[i]) begin
            m_k[i] = -1;
          end else if (!exp_level[i]) begin
            m_k[i] = 0;
            pulse[i] = 1'b1;
          end else begin
            m_k[i] = m_k[i] + 1;
            if (MASK[i] && m_k[i] >= DLY && (m_k[i] - DLY) % RATE == 0) pulse[i] = 1'b1;
          end
        end
      end
      m_cyc = m_cyc + 1;
      exp_level = nl;
      exp_bout = pulse;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  task automatic test_reset();
    int n2 = 0, n1 = 0, n0 = 0;
    rst = 1'b0;
    nbin = 3'b000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bout !== 3'b000 || level !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d bout=%b level=%b want 000/000", c, bout, level);
      end
    end
    rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (bout !== exp_bout || level !== exp_level) begin
        errors++;
        $display("FAIL reset_release cyc %0d bout=%b want %b level=%b want %b",
                 c, bout, exp_bout, level, exp_level);
      end
      if (bout[2] === 1'b1) n2++;
      if (bout[1] === 1'b1) n1++;
      if (bout[0] === 1'b1) n0++;
    end
    checks++;
    if (n2 != 4 || n1 != 4 || n0 != 1) begin
      errors++;
      $display("FAIL reset_pulse_count got %0d/%0d/%0d want 4/4/1", n2, n1, n0);
    end
    nbin = 3'b111;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if (bout !== exp_bout || level !== exp_level) begin
        errors++;
        $display("FAIL reset_settle cyc %0d bout=%b want %b level=%b want %b",
                 c, bout, exp_bout, level, exp_level);
      end
    end
  endtask

  task automatic test_clean_press();
    int np = 0, nl = 0;
    for (int c = 0; c < 36; c++) begin
      nbin = (c < 12) ? 3'b011 : 3'b111;
      @(negedge clk);
      checks++;
      if (bout !== exp_bout || level !== exp_level) begin
        errors++;
        $display("FAIL clean_model cyc %0d bout=%b want %b level=%b want %b",
                 c, bout, exp_bout, level, exp_level);
      end
      if (bout[2] === 1'b1) np++;
      if (level[2] === 1'b1) nl++;
    end
    checks++;
    if (np != 1 || nl != 12) begin
      errors++;
      $display("FAIL clean_press pulses=%0d want 1 level_cycles=%0d want 12", np, nl);
    end
  endtask

  task automatic test_bounce();
    int np = 0, nl = 0;
    for (int r = 0; r < 6; r++) begin
      int gap;
      gap = $urandom_range(0, 7);
      for (int c = 0; c < gap + 14; c++) begin
        nbin = (c >= gap && c < gap + 2) ? 3'b101 : 3'b111;
        @(negedge clk);
        checks++;
        if (bout !== exp_bout || level !== exp_level) begin
          errors++;
          $display("FAIL bounce_model rep %0d cyc %0d bout=%b want %b level=%b want %b",
                   r, c, bout, exp_bout, level, exp_level);
        end
        if (bout[1] === 1'b1) np++;
        if (level[1] === 1'b1) nl++;
      end
    end
    nbin = 3'b111;
    checks++;
    if (np != 0 || nl != 0) begin
      errors++;
      $display("FAIL bounce_reject pulses=%0d level_cycles=%0d want 0/0", np, nl);
    end
  endtask

  task automatic test_hold_repeat();
    int q[$];
    for (int c = 0; c < 68; c++) begin
      nbin = (c < 44) ? 3'b101 : 3'b111;
      @(negedge clk);
      checks++;
      if (bout !== exp_bout || level !== exp_level) begin
        errors++;
        $display("FAIL hold_model cyc %0d bout=%b want %b level=%b want %b",
                 c, bout, exp_bout, level, exp_level);
      end
      if (bout[1] === 1'b1) q.push_back(c);
    end
    checks++;
    if (q.size() != 5) begin
      errors++;
      $display("FAIL hold_count got %0d want 5", q.size());
    end else begin
      for (int k = 1; k < 5; k++) begin
        checks++;
        if (q[k] - q[k-1] != ((k == 1) ? DLY * SD : RATE * SD)) begin
          errors++;
          $display("FAIL hold_spacing %0d got %0d want %0d", k, q[k] - q[k-1],
                   (k == 1) ? DLY * SD : RATE * SD);
        end
      end
    end
  endtask

  task automatic test_clr_no_repeat();
    int n0 = 0, nother = 0;
    for (int c = 0; c < 68; c++) begin
      nbin = (c < 44) ? 3'b110 : 3'b111;
      @(negedge clk);
      checks++;
      if (bout !== exp_bout || level !== exp_level) begin
        errors++;
        $display("FAIL clr_model cyc %0d bout=%b want %b level=%b want %b",
                 c, bout, exp_bout, level, exp_level);
      end
      if (bout[0] === 1'b1) n0++;
      if (bout[2:1] !== 2'b00) nother++;
    end
    checks++;
    if (n0 != 1 || nother != 0) begin
      errors++;
      $display("FAIL clr_once pulses=%0d other=%0d want 1/0", n0, nother);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int seen = 0;
    bit hit = 1'b0;
    int q2[$], q1[$];
    nbin = 3'b001;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      checks++;
      if (bout !== exp_bout || level !== exp_level) begin
        errors++;
        $display("FAIL rstmid_model cyc %0d bout=%b want %b level=%b want %b",
                 c, bout, exp_bout, level, exp_level);
      end
      if (bout[2] === 1'b1) seen++;
      if (seen == 3) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rstmid_timeout pulses=%0d want 3", seen);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bout !== 3'b000 || level !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_reset_cycle bout=%b level=%b want 000/000", bout, level);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bout !== 3'b000 || level !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_after bout=%b level=%b want 000/000", bout, level);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (bout !== exp_bout || level !== exp_level) begin
        errors++;
        $display("FAIL rstmid_restart cyc %0d bout=%b want %b level=%b want %b",
                 c, bout, exp_bout, level, exp_level);
      end
      if (bout[2] === 1'b1) q2.push_back(c);
      if (bout[1] === 1'b1) q1.push_back(c);
    end
    checks++;
    if (q2.size() != 4 || q1.size() != 4 || q2[0] != q1[0] || q2[1] - q2[0] != DLY * SD) begin
      errors++;
      $display("FAIL rstmid_fresh counts=%0d/%0d want 4/4 (press together, then delay %0d)",
               q2.size(), q1.size(), DLY * SD);
    end
    nbin = 3'b111;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if (bout !== exp_bout || level !== exp_level) begin
        errors++;
        $display("FAIL rstmid_settle cyc %0d bout=%b want %b level=%b want %b",
                 c, bout, exp_bout, level, exp_level);
      end
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      nbin = 3'($urandom);
      len = $urandom_range(1, 24);
      if ($urandom_range(0, 15) == 0) rst = 1'b0;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (bout !== exp_bout || level !== exp_level) begin
          errors++;
          $display("FAIL random seg %0d cyc %0d bout=%b want %b level=%b want %b",
                   seg, c, bout, exp_bout, level, exp_level);
        end
      end
    end
    nbin = 3'b111;
  endtask

  initial begin
    rst = 1'b0;
    nbin = 3'b111;
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_repeat();
    test_clr_no_repeat();
    test_reset_mid_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_rpt.md
# btn_rpt

Debounced, auto-repeating push-button front end for the clock's set keys. Converts the three raw active-low keys into single-cycle, active-high command pulses for the seconds/minutes counters and the clear logic. A key held down produces one pulse on press and, on enabled channels, a steady stream of repeat pulses so the time can be fast-set. Drop-in upstream of the CNT60 chain, replacing the plain debouncer.

## Interface
- SAMPLE_DIV, 500000: CLK cycles per sample tick (10 ms at 50 MHz); ≥2.
- REPEAT_DELAY, 50: ticks from the press pulse to the first repeat pulse (500 ms); ≥1.
- REPEAT_RATE, 10: ticks between consecutive repeat pulses (100 ms); ≥1.
- REPEAT_MASK, 3'b110: per-channel repeat enable; bit2=secup, bit1=minup, bit0=clr (no repeat on clear).
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-low reset.
- nBIN  in  3  raw keys, active-low, asynchronous to CLK, bouncy.
- BOUT  out  3  one-CLK-wide command pulses, active-high; bit order {secup, minup, clr}.
- LEVEL  out  3  debounced key level, active-high (1 = held).

## Operation
- Synchronizer: 2-FF per bit on ~nBIN → s[2:0]; reset to 0 (released).
- Tick counter: 0..SAMPLE_DIV-1, wraps; tick = (count == SAMPLE_DIV-1). Reset to 0. Shared by all channels.
- Debounce per channel: on tick, prev <= s; if s == prev, LEVEL <= s. A level change needs two consecutive equal samples; any glitch shorter than one tick period that is not sampled twice is rejected. prev and LEVEL reset to 0.
- Per-channel FSM, advanced only on ticks:
  - IDLE: LEVEL 0→1 on this tick → issue pulse, rcnt <= 0, go WAIT.
  - WAIT: if LEVEL==0 → IDLE. Else if REPEAT_MASK bit==0 → stay. Else rcnt++; when rcnt reaches REPEAT_DELAY-1 → pulse, rcnt <= 0, go RPT.
  - RPT: if LEVEL==0 → IDLE. Else rcnt++; when rcnt reaches REPEAT_RATE-1 → pulse, rcnt <= 0.
- Release check precedes counting: a tick on which LEVEL falls never emits a pulse.
- Counters sized for max(REPEAT_DELAY, REPEAT_RATE); no overflow possible since they clear on terminal count.
- Channels fully independent; simultaneous presses produce simultaneous pulses in the same cycle.

## Timing
- All outputs registered. Reset values: BOUT=3'b000, LEVEL=3'b000, all FSMs IDLE, rcnt=0.
- BOUT pulse: exactly one CLK, in the cycle after the deciding tick; at most one pulse per channel per tick period.
- Press latency: 2 cycles sync + up to two tick periods to confirm + 1 cycle register.
- Pulse spacing while held on enabled channel: press pulse at tick T0, repeats at T0+REPEAT_DELAY, then every REPEAT_RATE ticks.
- Key held through reset release: treated as a fresh press (LEVEL starts 0), one press pulse after debounce.
- RST low mid-repeat: next edge returns everything to reset values; no pulse in the reset cycle or the cycle after.
- REPEAT_DELAY=1 or REPEAT_RATE=1: pulse on every qualifying tick; legal.

## Test plan
(SAMPLE_DIV=4, REPEAT_DELAY=3, REPEAT_RATE=2, REPEAT_MASK=3'b110.)
- Reset: RST=0 for 10 cycles with nBIN=3'b000 → BOUT=0, LEVEL=0 throughout; after release, exactly one pulse on each bit once debounced, then repeats on bits 2,1 only.
- Clean press bit2 for 3 ticks then release → one BOUT[2] pulse, 1 CLK wide; LEVEL[2] high 3 ticks; no repeat (released before delay).
- Bounce: nBIN[1] low for 2 CLK mid-period, then high → no pulse, LEVEL[1] stays 0.
- Hold bit1 for 10 ticks after press tick T0 → BOUT[1] pulses at T0, T0+3, T0+5, T0+7, T0+9 (5 pulses); release → no further pulse.
- Hold bit0 (clr) 10 ticks → exactly one BOUT[0] pulse.
- Hold bits 2 and 1 together, assert RST for 1 cycle after second repeat → BOUT=0 two cycles, LEVEL=0, then fresh press pulse and restarted delay on both.
